spi_master_regs: RTL and testbench
==================================

Name: spi_master_regs

Overview:
- SPI controller (initiator) that issues single register-access frames to the SPI register slave used in the ALU tile.
- Accepts a local write or read request, serialises one frame on CS/SCLK/MOSI, and captures MISO. Read data is returned on a one-cycle done pulse.
- Frame layout: rw (1 = write), then address, then data. All fields are sent MSB-first.
- Serves as the reference initiator for the chip's register interface on test boards and in system benches.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period. Legal minimum is 2. Use ≥4 when the slave sits behind 2-flop synchronisers.
- ADDR_WIDTH, 7, address field width.
- REG_WIDTH, 8, data field width.
- Derived FRAME = 1+ADDR_WIDTH+REG_WIDTH (16 at defaults).

Ports:
- clk  in  1  system clock
- rstb  in  1  asynchronous reset, active low
- ena  in  1  clock enable; when low, all state holds
- mode  in  2  {cpol,cpha}, sampled at start acceptance
- start  in  1  request strobe
- rw  in  1  1=write, 0=read; sampled with start
- addr  in  ADDR_WIDTH  register address; sampled with start
- wdata  in  REG_WIDTH  write data; sampled with start, sent as zeros-don't-care on reads
- busy  out  1  high from the cycle after acceptance until the done cycle
- done  out  1  one-cycle pulse at frame completion
- rdata  out  REG_WIDTH  read result
- spi_cs_n  out  1  chip select, active low
- spi_clk  out  1  SCLK
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in

Behaviour:
- Reset values: busy=0, done=0, rdata=0, spi_cs_n=1, spi_clk=0, spi_mosi=0. Reset is async, takes effect immediately, and aborts any frame (CS rises at once).
- States: IDLE, SETUP, XFER, HOLD, GAP. Every non-IDLE phase lasts exactly CLK_DIV enabled cycles. A divider counter (0..CLK_DIV-1) produces a tick on its last count.
- IDLE:
  - spi_clk tracks mode[1] (registered); cs_n=1.
  - start accepted only in IDLE with ena=1. The cycle after acceptance: SETUP, cs_n=0, busy=1.
  - mode, rw, addr and wdata are latched into a FRAME-bit shift register at acceptance.
  - start while busy is ignored, with no queuing.
- SETUP: cs_n low, SCLK at idle level. MOSI presents frame MSB when cpha=0.
- XFER:
  - 2*FRAME half-periods; SCLK toggles at each tick.
  - cpha=0: sample MISO on leading edges; shift MOSI on trailing edges.
  - cpha=1: shift MOSI on leading edges, with the first bit driven at the first leading edge; sample MISO on trailing edges.
  - MISO bits sampled during the last REG_WIDTH bit-times form rdata.
- HOLD: SCLK back at idle level, cs_n still 0.
- GAP: cs_n=1, mosi=0, guaranteeing CS-high time ≥ CLK_DIV.
- Completion:
  - At the end of GAP: return to IDLE, done=1 for one cycle, busy=0 in that same cycle.
  - On a read, rdata updates in the done cycle. On a write, rdata holds its previous value.
- Latency: acceptance at cycle 0 gives done at cycle 1+(2*FRAME+3)*CLK_DIV (141 at defaults). cs_n is low for (2*FRAME+2)*CLK_DIV cycles (136).
- ena=0: divider, state, shift register and all outputs freeze. done is not extended: a pulse coinciding with ena falling still lasts one cycle.
- mode changes mid-frame have no effect.

Test Plan:
- Mode 0, write: start with rw=1, addr=2, wdata=0x35 → MOSI sampled on SCLK rising edges reads 0x8235. cs_n low for 136 cycles. done at cycle 141. busy high for cycles 1–140.
- Mode 0, read: rw=0, addr=4, slave model returns 0xC4 → MOSI frame 0x0400, rdata=0xC4 in the done cycle, and rdata=0xC4 persists afterwards.
- Mode 3 (cpol=1, cpha=1) read of 0xAA and mode 1 read of 0x55 → SCLK idles high for mode 3 and low for mode 1. Data is sampled on the correct edges and rdata matches each value.
- start pulsed at cycles 10 and 140 during a frame → ignored, with exactly one done. start at the done cycle is also ignored. start at done+1 is accepted.
- Reset asserted mid-XFER at cycle 60 → in the same cycle cs_n=1, busy=0, spi_clk=0, and no done. A new frame after reset completes normally.
- ena held low for 20 cycles mid-frame → SCLK and state frozen, and done is delayed by exactly 20 cycles (cycle 161).

Source files
------------

// File: rtl/spi_master_regs_if.sv
// Local request/response bus of the SPI register initiator: the requester
// presents one access with start and gets read data back on done.
interface spi_master_regs_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int REG_WIDTH  = 8
) ();
  logic [1:0]            mode;   // {cpol, cpha}
  logic                  start;
  logic                  rw;     // 1 = write
  logic [ADDR_WIDTH-1:0] addr;
  logic [REG_WIDTH-1:0]  wdata;
  logic                  busy;
  logic                  done;
  logic [REG_WIDTH-1:0]  rdata;

  modport master (output mode, start, rw, addr, wdata, input busy, done, rdata);
  modport slave  (input mode, start, rw, addr, wdata, output busy, done, rdata);
endinterface

// File: rtl/spi_master_regs.sv
// SPI initiator issuing single {rw, addr, data} register frames, MSB first,
// in any of the four SPI modes; read data is returned with the done pulse.
module spi_master_regs #(
  parameter int CLK_DIV    = 4,
  parameter int ADDR_WIDTH = 7,
  parameter int REG_WIDTH  = 8
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            ena,
  spi_master_regs_if.slave bus,
  output logic            spi_cs_n,
  output logic            spi_clk,
  output logic            spi_mosi,
  input  logic            spi_miso
);

  localparam int FRAME  = 1 + ADDR_WIDTH + REG_WIDTH;
  localparam int HALVES = 2 * FRAME;
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int HALF_W = $clog2(HALVES);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_cnt;
  logic [HALF_W-1:0]     half_cnt;
  logic [FRAME-1:0]      tx_sh;
  logic [FRAME-1:0]      frame_word;
  logic [REG_WIDTH-1:0]  rx_sh;
  logic [REG_WIDTH-1:0]  rdata_q;
  logic                  cpha_q, rw_q, busy_q, done_q;
  logic                  tick, accept, last_half, sample_edge;

  assign tick        = (state_q != S_IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_half   = (half_cnt == HALF_W'(HALVES - 1));
  // Even half-periods end on a leading edge; cpha selects which edge samples.
  assign sample_edge = (half_cnt[0] == cpha_q);
  assign frame_word  = {bus.rw, bus.addr, bus.rw ? bus.wdata : {REG_WIDTH{1'b0}}};

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: defaults come first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (ena) begin
      case (state_q)
        S_IDLE: begin
          // The done cycle is not an acceptance slot; a start there is dropped.
          if (bus.start && !done_q) begin
            accept  = 1'b1;
            state_d = S_SETUP;
          end
        end
        S_SETUP: if (tick) state_d = S_XFER;
        S_XFER:  if (tick && last_half) state_d = S_HOLD;
        S_HOLD:  if (tick) state_d = S_GAP;
        S_GAP:   if (tick) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      div_cnt  <= '0;
      half_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rdata_q  <= '0;
      cpha_q   <= 1'b0;
      rw_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      // Outside the enable so a pulse coinciding with ena falling stays one cycle.
      done_q <= (state_q == S_GAP) && (state_d == S_IDLE);
      if (ena) begin
        busy_q   <= (state_d != S_IDLE);
        spi_cs_n <= (state_d == S_IDLE) || (state_d == S_GAP);
        div_cnt  <= (state_q == S_IDLE || tick) ? '0 : div_cnt + 1'b1;
        case (state_q)
          S_IDLE: begin
            spi_clk  <= bus.mode[1];
            half_cnt <= '0;
            if (accept) begin
              cpha_q <= bus.mode[0];
              rw_q   <= bus.rw;
              if (bus.mode[0]) begin
                tx_sh    <= frame_word;
                spi_mosi <= 1'b0;
              end else begin
                tx_sh    <= frame_word << 1;
                spi_mosi <= frame_word[FRAME-1];
              end
            end
          end
          S_XFER: begin
            if (tick) begin
              spi_clk  <= ~spi_clk;
              half_cnt <= half_cnt + 1'b1;
              if (sample_edge) begin
                rx_sh <= {rx_sh[REG_WIDTH-2:0], spi_miso};
              end else begin
                spi_mosi <= tx_sh[FRAME-1];
                tx_sh    <= tx_sh << 1;
              end
            end
          end
          S_HOLD: if (tick) spi_mosi <= 1'b0;
          S_GAP:  if (tick && !rw_q) rdata_q <= rx_sh;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master_regs.sv
// Self-checking bench for spi_master_regs: directed and random frames against
// a protocol-level slave model and frame/latency expectations.
module tb_spi_master_regs;

  localparam int FRAME_CYC = 1 + (2 * 16 + 3) * 4;  // acceptance to done
  localparam int CS_LOW    = (2 * 16 + 2) * 4;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic ena = 1'b1;
  logic spi_cs_n, spi_clk, spi_mosi;
  logic spi_miso = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] ref_rdata = 8'h00;

  spi_master_regs_if #(.ADDR_WIDTH(7), .REG_WIDTH(8)) bus ();

  spi_master_regs #(.CLK_DIV(4), .ADDR_WIDTH(7), .REG_WIDTH(8)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .bus      (bus),
    .spi_cs_n (spi_cs_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  // Register-slave model: shifts out s_tx MSB first, collects MOSI into s_rx.
  logic [15:0] s_tx = 16'h0;
  logic [15:0] s_rx = 16'h0;
  int          s_bits = 0;
  logic        s_cpol = 1'b0, s_cpha = 1'b0;
  logic        prev_cs = 1'b1, prev_clk = 1'b0;

  always @(spi_cs_n or spi_clk) begin
    if (spi_cs_n !== prev_cs) begin
      prev_cs = spi_cs_n;
      if (spi_cs_n === 1'b0) begin
        s_bits   = 0;
        s_rx     = 16'h0;
        spi_miso = s_cpha ? 1'b0 : s_tx[15];
      end
    end else if (spi_clk !== prev_clk && spi_cs_n === 1'b0) begin
      if (spi_clk !== s_cpol) begin
        if (!s_cpha) s_rx = {s_rx[14:0], spi_mosi};
        else if (s_bits < 16) spi_miso = s_tx[15 - s_bits];
      end else begin
        if (s_cpha) s_rx = {s_rx[14:0], spi_mosi};
        s_bits++;
        if (!s_cpha && s_bits < 16) spi_miso = s_tx[15 - s_bits];
      end
    end
    prev_clk = spi_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one frame starting at a negedge. stall: ena low for that many cycles from cycle 50.
  // pulse_at_done: also pulse start in the done cycle and return right there.
  // b2b: called directly after a pulse_at_done frame; start goes in at done+1.
  task automatic do_frame(input logic [1:0] m, input logic w, input logic [6:0] a,
                          input logic [7:0] d, input logic [7:0] resp, input int stall,
                          input bit pulse_at_done, input bit b2b);
    int exp_done, done_cyc, n_done, cs_low, busy_cnt, toggles, last_k;
    logic busy_done, prev_sclk;
    logic [7:0] got_rdata;
    logic [15:0] exp_frame;
    exp_done  = FRAME_CYC + stall;
    exp_frame = {w, a, w ? d : 8'h00};
    last_k    = pulse_at_done ? exp_done : exp_done + 3;
    done_cyc = 0; n_done = 0; cs_low = 0; busy_cnt = 0; toggles = 0;
    busy_done = 1'b1; got_rdata = 8'h00; prev_sclk = 1'b0;
    s_tx = {8'h00, resp};
    s_cpol = m[1];
    s_cpha = m[0];
    bus.mode = m;
    if (b2b) begin
      @(negedge clk);
      check("busy_after_done", 32'(bus.busy), 32'd0);
    end else begin
      repeat (2) @(negedge clk);
      check("idle_sclk", 32'(spi_clk), 32'(m[1]));
      check("idle_cs_n", 32'(spi_cs_n), 32'd1);
    end
    check("rdata_idle", 32'(bus.rdata), 32'(ref_rdata));
    bus.start = 1'b1;
    bus.rw    = w;
    bus.addr  = a;
    bus.wdata = d;
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      if (spi_cs_n === 1'b0) cs_low++;
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc  = k;
          busy_done = bus.busy;
          got_rdata = bus.rdata;
        end
      end
      if (stall > 0 && k > 50 && k <= 50 + stall && spi_clk !== prev_sclk) toggles++;
      prev_sclk = spi_clk;
      bus.start = (k == 10) || (k == exp_done - 1) || (pulse_at_done && k == exp_done);
      if (k <= 100) begin
        bus.mode  = 2'($urandom);
        bus.rw    = 1'($urandom);
        bus.addr  = 7'($urandom);
        bus.wdata = 8'($urandom);
      end else begin
        bus.mode = m;
      end
      if (stall > 0) ena = !(k >= 50 && k < 50 + stall);
    end
    bus.start = 1'b0;
    if (!w) ref_rdata = resp;
    check("done_cycle", 32'(done_cyc), 32'(exp_done));
    check("done_count", 32'(n_done), 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'(exp_done - 1));
    check("busy_at_done", 32'(busy_done), 32'd0);
    check("cs_low_cycles", 32'(cs_low), 32'(CS_LOW + stall));
    check("mosi_frame", 32'(s_rx), 32'(exp_frame));
    check("slave_bits", 32'(s_bits), 32'd16);
    check("rdata_done", 32'(got_rdata), 32'(ref_rdata));
    if (stall > 0) check("stall_sclk_toggles", 32'(toggles), 32'd0);
  endtask

  initial begin
    int dones;
    bus.mode = 2'b00; bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_sclk", 32'(spi_clk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    rstb = 1'b1;

    do_frame(2'd0, 1'b1, 7'd2, 8'h35, 8'h00, 0, 1'b0, 1'b0);
    do_frame(2'd0, 1'b0, 7'd4, 8'h5A, 8'hC4, 0, 1'b0, 1'b0);
    do_frame(2'd3, 1'b0, 7'd9, 8'h00, 8'hAA, 0, 1'b0, 1'b0);
    do_frame(2'd1, 1'b0, 7'd17, 8'h00, 8'h55, 0, 1'b0, 1'b0);
    do_frame(2'd2, 1'b1, 7'h33, 8'hE1, 8'h00, 0, 1'b1, 1'b0);
    do_frame(2'd2, 1'b0, 7'h41, 8'h00, 8'h3C, 0, 1'b0, 1'b1);
    do_frame(2'd0, 1'b0, 7'h11, 8'h00, 8'h96, 20, 1'b0, 1'b0);

    // Reset in the middle of XFER aborts the frame immediately.
    bus.mode = 2'd0;
    s_cpol = 1'b0; s_cpha = 1'b0; s_tx = 16'h00F0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.rw = 1'b0; bus.addr = 7'h05;
    dones = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done === 1'b1) dones++;
    end
    check("busy_pre_reset", 32'(bus.busy), 32'd1);
    rstb = 1'b0;
    #1;
    check("reset_cs_n", 32'(spi_cs_n), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_sclk", 32'(spi_clk), 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    check("reset_no_done", 32'(dones), 32'd0);
    check("reset_rdata", 32'(bus.rdata), 32'd0);
    rstb = 1'b1;
    ref_rdata = 8'h00;
    do_frame(2'd0, 1'b0, 7'h7F, 8'h00, 8'h81, 0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      do_frame(2'($urandom), 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom),
               0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
